// File: rtl/status_cond_eval_if.sv
// Condition query / result handshake between the control unit (master)
// and the status condition evaluator (slave).
interface status_cond_eval_if;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_ready;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;

  modport master (
    output cond_valid, cond, res_ready,
    input  cond_ready, res_valid, res_taken
  );

  modport slave (
    input  cond_valid, cond, res_ready,
    output cond_ready, res_valid, res_taken
  );
endinterface

// File: rtl/status_cond_eval.sv
// status_cond_eval: registers ALU N/Z/C/V flags, answers condition-code
// queries with one-cycle latency through a valid/ready handshake, and keeps
// a sticky overflow bit plus a saturating overflow event counter.
module status_cond_eval #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Zero,
  input  logic             Negative,
  input  logic             Overflow,
  input  logic             Carry,
  input  logic             flags_we,
  input  logic             clr_sticky,
  status_cond_eval_if.slave q,
  output logic [3:0]       flags_q,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state_reg, state_next;
  logic       taken_reg, taken_next;
  logic       res_valid;
  logic       accept;
  logic [3:0] flags_in;
  logic [3:0] flags_eff;
  logic       n_eff, z_eff, c_eff, v_eff;
  logic [7:0] base_pred;
  logic [15:0] cond_vec;

  // Incoming flags in {N,Z,C,V} order; a same-cycle capture is forwarded
  // so a query never sees stale flags.
  assign flags_in  = {Negative, Zero, Carry, Overflow};
  assign flags_eff = flags_we ? flags_in : flags_q;
  assign {n_eff, z_eff, c_eff, v_eff} = flags_eff;

  // Condition codes come in complementary pairs: the even code is the base
  // predicate and the odd code its inverse (AL/NV included).
  assign base_pred = {1'b1,                          // AL / NV
                      !z_eff & (n_eff == v_eff),     // GT / LE
                      (n_eff == v_eff),              // GE / LT
                      c_eff & !z_eff,                // HI / LS
                      v_eff,                         // VS / VC
                      n_eff,                         // MI / PL
                      c_eff,                         // CS / CC
                      z_eff};                        // EQ / NE

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cond
      assign cond_vec[2*gi]   = base_pred[gi];
      assign cond_vec[2*gi+1] = !base_pred[gi];
    end
  endgenerate

  assign res_valid    = (state_reg == FULL);
  assign q.res_valid  = res_valid;
  assign q.res_taken  = taken_reg;
  assign q.cond_ready = !res_valid | q.res_ready;
  assign accept       = q.cond_valid & q.cond_ready;

  // Flag capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end
  end

  // Sticky overflow and saturating event counter; clear wins over a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end else if (clr_sticky) begin
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end else if (flags_we && Overflow) begin
      sticky_v <= 1'b1;
      if (ovf_count != {CNT_W{1'b1}}) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

  // Result FSM state register; reset drops res_valid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      taken_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      taken_reg <= taken_next;
    end
  end

  // Next-state: load on accept, drain to EMPTY when consumed without refill.
  always_comb begin
    state_next = state_reg;
    taken_next = taken_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = FULL;
          taken_next = cond_vec[q.cond];
        end
      end
      FULL: begin
        if (accept) begin
          taken_next = cond_vec[q.cond];
        end else if (q.res_ready) begin
          state_next = EMPTY;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_status_cond_eval.sv
// Directed self-checking bench for status_cond_eval. A second instance with a
// 2-bit counter shares the flag inputs to exercise counter saturation.
module tb_status_cond_eval;
  logic clk = 1'b0;
  logic rst;
  logic Zero, Negative, Overflow, Carry, flags_we, clr_sticky;
  logic [3:0] flags_q, flags_q_s;
  logic       sticky_v, sticky_s;
  logic [7:0] ovf_count;
  logic [1:0] ovf_s;

  int checks = 0;
  int errors = 0;

  status_cond_eval_if qif ();
  status_cond_eval_if qif_s ();

  status_cond_eval #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .Zero(Zero), .Negative(Negative), .Overflow(Overflow), .Carry(Carry),
    .flags_we(flags_we), .clr_sticky(clr_sticky),
    .q(qif),
    .flags_q(flags_q), .sticky_v(sticky_v), .ovf_count(ovf_count)
  );

  status_cond_eval #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .Zero(Zero), .Negative(Negative), .Overflow(Overflow), .Carry(Carry),
    .flags_we(flags_we), .clr_sticky(clr_sticky),
    .q(qif_s),
    .flags_q(flags_q_s), .sticky_v(sticky_s), .ovf_count(ovf_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic n, input logic z, input logic c, input logic v);
    Negative = n; Zero = z; Carry = c; Overflow = v;
  endtask

  // Single query against held flags; result must appear one cycle later.
  task automatic query(input string tag, input logic [3:0] code, input logic exp);
    qif.cond = code;
    qif.cond_valid = 1'b1;
    qif.res_ready = 1'b1;
    tick();
    chk(tag, qif.res_taken, exp);
    qif.cond_valid = 1'b0;
  endtask

  // Flags N=0 Z=1 C=1 V=0: hand-computed outcomes.
  logic [3:0] zc_code [9] = '{4'd2, 4'd3, 4'd0, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  logic       zc_exp  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  // Backpressure stream with flags Z=1 only: NE,EQ,NE,EQ,AL,NV.
  logic [3:0] bp_code [6] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd14, 4'd15};
  logic       bp_exp  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       exp_q [$];

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random inputs.
    rst = 1'b1;
    qif_s.cond_valid = 1'b0; qif_s.cond = 4'd0; qif_s.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_flags($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
      flags_we = $urandom_range(1);
      clr_sticky = $urandom_range(1);
      qif.cond_valid = $urandom_range(1);
      qif.cond = 4'($urandom_range(15));
      qif.res_ready = $urandom_range(1);
      tick();
    end
    set_flags(0, 0, 0, 0);
    flags_we = 0; clr_sticky = 0;
    qif.cond_valid = 0; qif.cond = 0; qif.res_ready = 0;
    rst = 1'b0;
    #1;
    chk("rst_flags_q", flags_q, 4'b0000);
    chk("rst_res_valid", qif.res_valid, 0);
    chk("rst_sticky", sticky_v, 0);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_cond_ready", qif.cond_ready, 1);

    // Forwarding: capture Z=1 and query EQ in the same cycle.
    set_flags(0, 1, 0, 0);
    flags_we = 1;
    qif.cond = 4'd0; qif.cond_valid = 1; qif.res_ready = 1;
    tick();
    chk("fwd_res_valid", qif.res_valid, 1);
    chk("fwd_eq_taken", qif.res_taken, 1);
    chk("fwd_flags_q", flags_q, 4'b0100);
    flags_we = 0;
    set_flags(0, 0, 0, 0);
    qif.cond = 4'd1;
    tick();
    chk("ne_taken", qif.res_taken, 0);
    qif.cond_valid = 0;
    tick();
    chk("drain_res_valid", qif.res_valid, 0);

    // Signed cases, N=1 V=0.
    set_flags(1, 0, 0, 0); flags_we = 1; tick(); flags_we = 0;
    query("ge_n1v0", 4'd10, 0);
    query("lt_n1v0", 4'd11, 1);
    query("le_n1v0", 4'd13, 1);
    // N=1 V=1, Z=0.
    set_flags(1, 0, 0, 1); flags_we = 1; tick(); flags_we = 0;
    query("gt_n1v1", 4'd12, 1);
    query("ge_n1v1", 4'd10, 1);

    // Unsigned and simple codes with N=0 Z=1 C=1 V=0.
    set_flags(0, 1, 1, 0); flags_we = 1; tick(); flags_we = 0;
    for (int i = 0; i < 9; i++) begin
      query($sformatf("zc_code%0d", zc_code[i]), zc_code[i], zc_exp[i]);
    end

    // AL/NV under every flag value; AL query uses forwarded flags.
    for (int f = 0; f < 16; f++) begin
      set_flags(f[3], f[2], f[1], f[0]);
      flags_we = 1;
      query($sformatf("al_f%0h", f), 4'd14, 1);
      flags_we = 0;
      query($sformatf("nv_f%0h", f), 4'd15, 0);
    end

    // Backpressure: start from EMPTY with Z=1 captured.
    qif.cond_valid = 0; qif.res_ready = 1; tick();
    set_flags(0, 1, 0, 0); flags_we = 1; tick(); flags_we = 0;
    qif.cond = 4'd0; qif.cond_valid = 1; qif.res_ready = 0;
    tick();
    exp_q.push_back(1'b1);
    qif.cond = 4'd1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_ready%0d", i), qif.cond_ready, 0);
      chk($sformatf("bp_taken%0d", i), qif.res_taken, 1);
      tick();
    end
    qif.res_ready = 1;
    for (int i = 0; i < 6; i++) begin
      qif.cond = bp_code[i];
      qif.cond_valid = 1;
      #1;
      chk($sformatf("sb_ready%0d", i), qif.cond_ready, 1);
      chk($sformatf("sb_valid%0d", i), qif.res_valid, 1);
      chk($sformatf("sb_taken%0d", i), qif.res_taken, exp_q.pop_front());
      exp_q.push_back(bp_exp[i]);
      tick();
    end
    qif.cond_valid = 0;
    while (exp_q.size() > 0) begin
      chk("sb_drain_valid", qif.res_valid, 1);
      chk("sb_drain_taken", qif.res_taken, exp_q.pop_front());
      tick();
    end
    chk("sb_empty", qif.res_valid, 0);

    // Saturation on the 2-bit counter; the 8-bit counter keeps counting.
    set_flags(0, 0, 0, 0);
    clr_sticky = 1; tick(); clr_sticky = 0;
    chk("clr_ovf_s", ovf_s, 0);
    chk("clr_sticky_s", sticky_s, 0);
    for (int i = 1; i <= 5; i++) begin
      set_flags(0, 0, 0, 1); flags_we = 1;
      tick();
      chk($sformatf("sat_ovf%0d", i), ovf_s, (i > 3) ? 3 : i);
      chk($sformatf("sat_sticky%0d", i), sticky_s, 1);
      chk($sformatf("ovf8_%0d", i), ovf_count, i);
    end
    clr_sticky = 1; flags_we = 1; set_flags(0, 0, 0, 1);
    tick();
    clr_sticky = 0; flags_we = 0;
    chk("clrcap_ovf_s", ovf_s, 0);
    chk("clrcap_sticky_s", sticky_s, 0);
    chk("clrcap_flags_s", flags_q_s, 4'b0001);
    chk("clrcap_ovf8", ovf_count, 0);
    chk("clrcap_flags", flags_q, 4'b0001);

    // Async reset while a result is held under backpressure.
    qif.cond = 4'd14; qif.cond_valid = 1; qif.res_ready = 0;
    tick();
    qif.cond_valid = 0;
    chk("pre_arst_valid", qif.res_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_valid", qif.res_valid, 0);
    chk("arst_flags", flags_q, 4'b0000);
    @(posedge clk); #1;
    rst = 0;
    set_flags(0, 0, 0, 0);
    qif.cond = 4'd7; qif.cond_valid = 1; qif.res_ready = 1;
    #1;
    chk("post_arst_ready", qif.cond_ready, 1);
    chk("post_arst_novalid", qif.res_valid, 0);
    tick();
    qif.cond_valid = 0;
    chk("post_arst_valid", qif.res_valid, 1);
    chk("post_arst_taken", qif.res_taken, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
